// File: rtl/rc4_stream_engine.sv
// RC4 keystream engine: owns the 256x8 S-box RAM port, runs init, key
// schedule and PRGA from one start pulse, streams OUT_LEN bytes out.
// Ports: clk/reset_n, start/key in, busy/done status, s_* single-port
// RAM (1-cycle read latency), ks_data/ks_valid/ks_ready keystream.
module rc4_stream_engine #(
  parameter int KEY_BYTES = 3,
  parameter int OUT_LEN   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   s_rden,
  input  logic [7:0]             s_q,
  output logic [7:0]             ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INC, S_RDI, S_WTI, S_RDJ, S_WTJ,
    S_WRI, S_WRJ, S_RDF, S_WTF, S_OUT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic                   prga_q, prga_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             ks_data_q, ks_data_d;
  logic                   ks_valid_q, ks_valid_d;

  logic [7:0] kbyte;
  logic [7:0] jn;

  // key byte 0 is the most significant byte of key
  always_comb begin
    kbyte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KW'(k)) kbyte = key_q[(KEY_BYTES-1-k)*8 +: 8];
    end
  end

  // s_q holds S[i] during RDJ; key byte only mixes in during KSA
  always_comb jn = j_q + s_q + (prga_q ? 8'd0 : kbyte);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    kidx_d     = kidx_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    prga_d     = prga_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
          prga_d  = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'd255) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = S_RDI;
        end
      end
      S_INC: begin
        i_d     = i_q + 8'd1;
        state_d = S_RDI;
      end
      S_RDI: state_d = S_WTI;
      S_WTI: state_d = S_RDJ;
      S_RDJ: begin
        si_d    = s_q;
        j_d     = jn;
        state_d = S_WTJ;
      end
      S_WTJ: state_d = S_WRI;
      S_WRI: begin
        sj_d    = s_q;
        state_d = S_WRJ;
      end
      S_WRJ: begin
        if (prga_q) begin
          state_d = S_RDF;
        end else if (i_q == 8'd255) begin
          i_d     = '0;
          j_d     = '0;
          prga_d  = 1'b1;
          state_d = S_INC;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
          state_d = S_RDI;
        end
      end
      S_RDF: state_d = S_WTF;
      S_WTF: begin
        ks_data_d  = s_q;
        ks_valid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (ks_ready) begin
          ks_valid_d = 1'b0;
          cnt_d      = cnt_q + 16'd1;
          if (cnt_q == 16'(OUT_LEN-1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_INC;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port decode; forced idle while reset_n is low
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    s_rden    = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_INIT: begin
          s_address = i_q;
          s_data    = i_q;
          s_wren    = 1'b1;
        end
        S_RDI: begin
          s_address = i_q;
          s_rden    = 1'b1;
        end
        S_RDJ: begin
          s_address = jn;
          s_rden    = 1'b1;
        end
        S_WRI: begin
          s_address = i_q;
          s_data    = s_q;
          s_wren    = 1'b1;
        end
        S_WRJ: begin
          s_address = j_q;
          s_data    = si_q;
          s_wren    = 1'b1;
        end
        S_RDF: begin
          s_address = si_q + sj_q;
          s_rden    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      kidx_q     <= '0;
      cnt_q      <= '0;
      key_q      <= '0;
      prga_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      kidx_q     <= kidx_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      prga_q     <= prga_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ks_data  = ks_data_q;
  assign ks_valid = ks_valid_q;

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Bench for rc4_stream_engine: RAM models, RC4 reference, known answers,
// random keys with random backpressure, ignored restart, mid-run reset.
module tb_rc4_stream_engine;

  localparam int OUT_LEN = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] key;
  logic        busy, done;
  logic [7:0]  s_address, s_data, s_q;
  logic        s_wren, s_rden;
  logic [7:0]  ks_data;
  logic        ks_valid, ks_ready;

  logic        start4;
  logic        busy4, done4;
  logic [7:0]  s_address4, s_data4, s_q4;
  logic        s_wren4, s_rden4;
  logic [7:0]  ks_data4;
  logic        ks_valid4;
  logic        ks_ready4 = 1'b1;

  always #5 clk = ~clk;

  rc4_stream_engine #(.KEY_BYTES(3), .OUT_LEN(OUT_LEN)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data),
    .s_wren(s_wren), .s_rden(s_rden), .s_q(s_q),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready)
  );

  rc4_stream_engine #(.KEY_BYTES(4), .OUT_LEN(5)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .key(32'h57696B69),
    .busy(busy4), .done(done4),
    .s_address(s_address4), .s_data(s_data4),
    .s_wren(s_wren4), .s_rden(s_rden4), .s_q(s_q4),
    .ks_data(ks_data4), .ks_valid(ks_valid4), .ks_ready(ks_ready4)
  );

  logic [7:0] mem [256];
  logic [7:0] mem4 [256];

  always @(posedge clk) begin
    if (s_wren) mem[s_address] <= s_data;
    if (s_rden) s_q <= mem[s_address];
    if (s_wren4) mem4[s_address4] <= s_data4;
    if (s_rden4) s_q4 <= mem4[s_address4];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic rc4_model(input logic [255:0] kv, input int kl,
                           input int n);
    int s[256];
    int i, j, t, kb;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      kb = int'(kv[(kl-1-(a%kl))*8 +: 8]);
      j = (j + s[a] + kb) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    exp_q.delete();
    for (int m = 0; m < n; m++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endtask

  // monitor state
  int         ncyc = 0;
  int         t0 = 0;
  int         fv = -1;
  int         wr_n = 0;
  int         trace_bad = 0;
  int         excl_bad = 0;
  int         hold_bad = 0;
  int         db_bad = 0;
  int         dones = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d = '0;
  logic       prev_busy = 1'b0;
  logic [7:0] got[$];
  logic [7:0] got4[$];

  always @(negedge clk) begin
    ncyc++;
    if (s_wren && s_rden) excl_bad++;
    if (s_wren) begin
      if (wr_n < 256) begin
        if (s_address != 8'(wr_n) || s_data != 8'(wr_n) ||
            ncyc != t0 + 1 + wr_n) trace_bad++;
      end
      wr_n++;
    end
    if (hold_pend && (!ks_valid || ks_data != hold_d)) hold_bad++;
    hold_pend = ks_valid && !ks_ready;
    hold_d    = ks_data;
    if (ks_valid && fv < 0) fv = ncyc - t0 - 1;
    if (ks_valid && ks_ready) got.push_back(ks_data);
    if (done) begin
      dones++;
      if (busy || !prev_busy) db_bad++;
    end
    prev_busy = busy;
    if (ks_valid4 && ks_ready4) got4.push_back(ks_data4);
  end

  task automatic launch(input logic [23:0] k);
    got.delete();
    dones = 0; wr_n = 0; fv = -1; trace_bad = 0;
    key = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = ncyc;
  endtask

  task automatic finish_run(input int mode, input int mid);
    int c;
    c = 0;
    while (dones == 0 && c < 30000) begin
      case (mode)
        0:       ks_ready = 1'b1;
        1:       ks_ready = (c % 3 == 2);
        default: ks_ready = 1'($urandom % 2);
      endcase
      start = (mid != 0 && c == 500);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    ks_ready = 1'b0;
    chk("timeout", 32'(dones != 0), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("done_once", dones, 1);
  endtask

  task automatic cmp_stream(input logic [23:0] k, input string tag);
    rc4_model({232'd0, k}, 3, OUT_LEN);
    chk({tag, "_len"}, got.size(), OUT_LEN);
    for (int i = 0; i < OUT_LEN && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask

  logic [7:0] ka [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                          8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] kw [5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};

  task automatic chk_key_ka(input string tag);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("%s_ka%0d", tag, i), got[i], ka[i]);
  endtask

  initial begin
    logic [23:0] rk;
    reset_n = 1'b0; start = 1'b0; start4 = 1'b0;
    ks_ready = 1'b0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_data", ks_data, 0);
    chk("rst_wren", s_wren, 0);
    chk("rst_rden", s_rden, 0);
    chk("rst_addr", s_address, 0);
    @(posedge clk); #1;

    // Wiki known answer on the 4-byte instance runs alongside test 1
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;

    launch(24'h4B6579);
    chk("busy_up", busy, 1);
    finish_run(0, 0);
    chk("lat", fv, 1801);
    chk("trace", trace_bad, 0);
    chk("wr_cnt", 32'(wr_n >= 256), 1);
    chk_key_ka("t1");
    cmp_stream(24'h4B6579, "t1");
    chk("w_len", got4.size(), 5);
    for (int i = 0; i < 5 && i < got4.size(); i++)
      chk($sformatf("wiki_%0d", i), got4[i], kw[i]);
    chk("w_done", done4 | busy4, 0);

    launch(24'h4B6579);
    finish_run(1, 0);
    chk_key_ka("bp");
    cmp_stream(24'h4B6579, "bp");

    for (int r = 0; r < 2; r++) begin
      rk = 24'($urandom);
      launch(rk);
      finish_run(2, 0);
      cmp_stream(rk, $sformatf("rnd%0d", r));
    end

    rk = 24'($urandom);
    launch(rk);
    finish_run(0, 1);
    chk("mid_lat", fv, 1801);
    cmp_stream(rk, "mid");

    // reset lands on a PRGA write cycle (WRI of the second byte)
    ks_ready = 1'b1;
    launch(24'h4B6579);
    repeat (1807) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstlo_wren", s_wren, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_valid", ks_valid, 0);
    chk("ab_data", ks_data, 0);
    chk("ab_wren", s_wren, 0);
    chk("ab_rden", s_rden, 0);
    chk("ab_addr", s_address, 0);
    chk("ab_wdata", s_data, 0);
    @(posedge clk); #1;
    launch(24'h4B6579);
    finish_run(0, 0);
    chk("re_lat", fv, 1801);
    chk("re_trace", trace_bad, 0);
    chk_key_ka("re");
    cmp_stream(24'h4B6579, "re");

    chk("excl", excl_bad, 0);
    chk("hold", hold_bad, 0);
    chk("done_busy", db_bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rc4_stream_engine.md
Name: rc4_stream_engine

Overview:
- Parametrised RC4 engine that owns the single-port 256x8 S-box RAM and runs three phases from one start pulse:
  - initialise: S[i]=i
  - key schedule: shuffle with a KEY_BYTES-long key
  - PRGA: emits OUT_LEN keystream bytes on a valid/ready stream
- Replaces separate init/shuffle FSMs and the external RAM mux.
- Downstream consumers XOR ks_data with ciphertext.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32). Key byte k = key[(KEY_BYTES-1-k)*8 +: 8], so byte 0 is the MSB byte.
- OUT_LEN, 32, number of keystream bytes produced per run (1..65535).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  single-cycle run request
- key  input  KEY_BYTES*8  secret key; sampled only on accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last keystream byte is accepted
- s_address  output  8  S-RAM address
- s_data  output  8  S-RAM write data
- s_wren  output  1  S-RAM write enable
- s_rden  output  1  S-RAM read enable
- s_q  input  8  S-RAM read data; valid the cycle after s_rden (1-cycle latency)
- ks_data  output  8  keystream byte
- ks_valid  output  1  keystream byte valid
- ks_ready  input  1  consumer accepts when ks_valid&&ks_ready at a rising edge

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (reset_n); all state is sampled at the rising edge.
- Reset values: state=IDLE, all outputs 0, i=j=0, output counter=0.
- Reset mid-run aborts immediately. No RAM write may occur in the cycle reset_n is low.
- IDLE:
  - start=1 latches key, sets busy, i=0, goes to INIT.
  - start while busy is ignored (no restart, no error).
- INIT: one write per cycle, address=i, data=i, s_wren=1; i increments. After i=255 is written: i=0, j=0, key index kidx=0, go to KSA. Exactly 256 cycles.
- KSA: 6 cycles per i.
  - RDI: s_rden, address=i.
  - WTI: wait.
  - RDJ: si=s_q; jn=j+si+keybyte[kidx] (mod 256); j<=jn; s_rden, address=jn.
  - WTJ: wait.
  - WRI: sj=s_q; write S[i]=sj.
  - WRJ: write S[j]=si.
  - After WRJ: i++, kidx wraps at KEY_BYTES-1 using a counter (no divider). After i=255 go to PRGA with i=0, j=0.
  - KSA total: 1536 cycles.
- PRGA, per byte:
  - INC: i=i+1.
  - RDI / WTI: read S[i].
  - RDJ: si=s_q; j=j+si; read S[j].
  - WTJ: wait.
  - WRI: sj=s_q; write S[i]=sj.
  - WRJ: write S[j]=si.
  - RDF: read address si+sj (mod 256).
  - WTF: wait.
  - OUT: ks_data=s_q (registered), ks_valid=1.
- Stream handshake:
  - ks_data is held stable while ks_valid && !ks_ready.
  - On acceptance ks_valid drops the next cycle. If OUT_LEN bytes have been sent, go to DONE; else go to INC.
  - Minimum 9 cycles between accepted bytes. ks_ready is ignored outside OUT.
- DONE: done=1 for one cycle, busy=0, return to IDLE. Next start reruns INIT from scratch.
- Arithmetic: all index arithmetic is 8-bit with natural wrap (255+1=0). The i=j case (swap onto itself) must leave S unchanged.
- RAM port: s_wren and s_rden are never high together. Address and data are driven only by this block.

Test Plan:
- KEY_BYTES=3, key=24'h4B6579 ("Key"), ks_ready=1 -> ks_data sequence EB 9F 77 81 B7 34 CA 72 A7 19; done pulses once; busy falls with done.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki") -> first bytes 60 44 DB 6D 41.
- Check RAM write trace: first 256 writes are addr=data=0..255 in consecutive cycles; first PRGA ks_valid occurs 256+1536+9 cycles after accepted start.
- Backpressure: ks_ready toggled 0/0/1 -> each byte held with identical ks_data until accepted, no byte lost or duplicated; same sequence as first test.
- Pulse start while busy mid-KSA -> ignored, output identical to the uninterrupted run.
- Pull reset_n low mid-PRGA -> next cycle all outputs 0 and state IDLE. A fresh start reproduces the first-test sequence exactly.
